fir_y_wb_buffer: RTL
====================

// Module: fir_y_wb_buffer
// PURPOSE
//   Downstream stage of the FIR user project. Captures the FIR AXI-Stream output
//   (sm_*) into a small FIFO and serves it to the management SoC over Wishbone.
//   Decouples FIR output timing from firmware polling: Y at 0x3000_0084, status at 0x3000_0088.
//   Provides a bounded-wait read, sticky tlast/timeout flags and a completion irq.
// PARAMETERS
//   DEPTH    8      FIFO entries; power of two, >=2
//   AW       3      log2(DEPTH)
//   TIMEOUT  1024   max cycles a Y read on an empty FIFO waits before a dummy ack; >=1
// PORTS
//   wb_clk_i     in   1   single clock, all logic on posedge
//   wb_rst_i     in   1   synchronous reset, active-high
//   wbs_stb_i    in   1   WB strobe
//   wbs_cyc_i    in   1   WB cycle
//   wbs_we_i     in   1   WB write enable
//   wbs_adr_i    in   32  WB address
//   wbs_dat_i    in   32  WB write data
//   wbs_ack_o    out  1   WB ack, one-cycle pulse
//   wbs_dat_o    out  32  WB read data, valid only while wbs_ack_o=1, else 0
//   sm_tvalid    in   1   FIR output stream valid
//   sm_tdata     in   32  FIR output sample y[n]
//   sm_tlast     in   1   last sample of frame
//   sm_tready    out  1   = !full
//   irq_o        out  1   = last_seen sticky flag
// BEHAVIOUR
//   Reset: FIFO empty (count=0), flags=0, FSM=IDLE; wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
//     sm_tready=0 while wb_rst_i=1, =1 on first cycle after reset release.
//     Reset mid-transaction: pending read is dropped, no ack issued.
//   Decode: sel = stb&cyc&(adr[31:24]==8'h30). Y: adr[7:0]==8'h84; STAT: adr[7:0]==8'h88.
//     Other addresses: never acked by this block.
//   FIFO: entries {tlast,tdata}. Push when sm_tvalid&sm_tready. Pop only on a Y-read ack.
//     Push+pop same cycle: count unchanged. Full: sm_tready=0, even if a pop happens that
//     cycle. Pointers wrap modulo DEPTH; count is AW+1 bits.
//     last_seen sets on push of an entry with tlast=1.
//   FSM states: IDLE, WAIT, ACK.
//     IDLE: Y read with count>0 -> ACK; Y read with count=0 -> WAIT, load timer=TIMEOUT.
//       STAT access or Y write -> ACK.
//     WAIT: count>0 -> ACK. timer reaches 0 -> ACK with data 0 and set timeout_flag.
//       stb or cyc dropped -> IDLE, no ack. Timer decrements once per cycle.
//     ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
//       Y read: wbs_dat_o = head tdata; pop on this edge.
//       Ack never asserted on two consecutive cycles.
//   Latency: Y read on non-empty FIFO acks the cycle after stb first seen (2-cycle access).
//     Data arriving while in WAIT is acked the cycle after it is written; no bypass path.
//   Y write: acked, data discarded.
//   STAT read (32b): [0] empty, [1] full, [2] last_seen, [3] timeout_flag,
//     [8+AW:8] count, others 0.
//   STAT write: W1C on bits [2] and [3] using wbs_dat_i. If a clear and a set of
//     last_seen occur in the same cycle, the set wins.
// TESTING
//   1. Reset, stream 3 samples (5,-7,9), tlast on 9 -> STAT reads 0x0000_0304;
//      3 Y reads return 5,0xFFFF_FFF9,9; final STAT = 0x0000_0005; irq_o=1.
//   2. Hold sm_tvalid=1 with no reads -> exactly DEPTH pushes; sm_tready=0; STAT[1]=1, count=8.
//      One Y read re-raises sm_tready the next cycle.
//   3. Y read on empty FIFO, push 0x1234 after 10 cycles -> ack the cycle after the push,
//      data 0x1234, count back to 0.
//   4. Y read on empty FIFO, no data -> ack after TIMEOUT+1 cycles, data 0, STAT[3]=1;
//      write 0x8 to 0x3000_0088 -> STAT[3]=0.
//   5. Concurrent push and pop at count=4 -> count stays 4; order preserved over 2*DEPTH
//      samples across pointer wrap.
//   6. Assert wb_rst_i during WAIT and with a full FIFO -> no ack; next cycle count=0 and
//      flags=0; sm_tready=1 after release.

Source files
------------

// File: rtl/fir_y_wb_buffer_if.sv
// Wishbone slave and AXI-Stream sink bundle for the FIR Y-output buffer.
// Signal names follow the SoC-facing wbs_*/sm_* naming of the user project.
interface fir_y_wb_buffer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready;
    logic        irq_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready, irq_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready, irq_o
    );
endinterface

// File: rtl/fir_y_wb_buffer.sv
// FIR output buffer: captures the sm_* stream into a FIFO and serves Y/STAT
// to firmware over Wishbone with a bounded-wait read and sticky flags.
module fir_y_wb_buffer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    fir_y_wb_buffer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    typedef enum logic [1:0] {K_Y_RD, K_STAT_RD, K_STAT_WR, K_NO_DATA} kind_t;

    state_t        state, state_nx;
    kind_t         kind, kind_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          tmo_set;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          last_seen, timeout_flag;

    logic          empty, full, push, pop, ack, stat_clr;
    logic          sel, y_sel, stat_sel;
    logic [32:0]   head;
    logic [31:0]   status;
    logic          unused_bits;

    // Address decode
    assign sel      = bus.wbs_stb_i && bus.wbs_cyc_i && (bus.wbs_adr_i[31:24] == 8'h30);
    assign y_sel    = sel && (bus.wbs_adr_i[7:0] == 8'h84);
    assign stat_sel = sel && (bus.wbs_adr_i[7:0] == 8'h88);

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // Ready is held low during reset even though count is only cleared at the edge
    assign bus.sm_tready = !full && !wb_rst_i;
    assign push          = bus.sm_tvalid && bus.sm_tready;

    assign ack      = (state == S_ACK) && !wb_rst_i;
    assign pop      = ack && (kind == K_Y_RD);
    assign stat_clr = ack && (kind == K_STAT_WR);

    assign bus.wbs_ack_o = ack;
    assign bus.irq_o     = last_seen;

    always_comb begin
        status        = '0;
        status[0]     = empty;
        status[1]     = full;
        status[2]     = last_seen;
        status[3]     = timeout_flag;
        status[8+AW:8] = count;
    end

    always_comb begin
        bus.wbs_dat_o = '0;
        if (ack) begin
            case (kind)
                K_Y_RD:    bus.wbs_dat_o = head[31:0];
                K_STAT_RD: bus.wbs_dat_o = status;
                default:   bus.wbs_dat_o = '0;
            endcase
        end
    end

    // Access FSM
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            kind  <= K_NO_DATA;
            timer <= '0;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            timer <= timer_nx;
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        timer_nx = timer;
        tmo_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (y_sel && !bus.wbs_we_i) begin
                    if (!empty) begin
                        state_nx = S_ACK;
                        kind_nx  = K_Y_RD;
                    end else begin
                        state_nx = S_WAIT;
                        timer_nx = TW'(TIMEOUT);
                    end
                end else if (y_sel) begin
                    state_nx = S_ACK;
                    kind_nx  = K_NO_DATA;
                end else if (stat_sel) begin
                    state_nx = S_ACK;
                    kind_nx  = bus.wbs_we_i ? K_STAT_WR : K_STAT_RD;
                end
            end
            S_WAIT: begin
                // Data arrival outranks a timeout expiring in the same cycle
                if (!(bus.wbs_stb_i && bus.wbs_cyc_i)) begin
                    state_nx = S_IDLE;
                end else if (!empty) begin
                    state_nx = S_ACK;
                    kind_nx  = K_Y_RD;
                end else if (timer <= TW'(1)) begin
                    state_nx = S_ACK;
                    kind_nx  = K_NO_DATA;
                    tmo_set  = 1'b1;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {bus.sm_tlast, bus.sm_tdata};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_seen    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (stat_clr && bus.wbs_dat_i[2]) begin
                last_seen <= 1'b0;
            end
            if (push && bus.sm_tlast) begin
                last_seen <= 1'b1;
            end
            if (stat_clr && bus.wbs_dat_i[3]) begin
                timeout_flag <= 1'b0;
            end
            if (tmo_set) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign unused_bits = ^{bus.wbs_adr_i[23:8], bus.wbs_dat_i[31:4], bus.wbs_dat_i[1:0], head[32]};
endmodule
